// File: rtl/vga_mem_arbiter_if.sv
// +-------------------------------------------------------------------------+
// | vga_mem_arbiter_if : VGA / CPU / RAM bundle around the image-RAM arbiter |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              video_on_i;
  logic [ADDR_W-1:0] vga_addr_i;
  logic [DATA_W-1:0] vga_pixel_o;
  logic              vga_stall_o;
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_ack_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  // Arbiter side
  modport slave (
    input  video_on_i, vga_addr_i, cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_rdata_i,
    output vga_pixel_o, vga_stall_o, cpu_ack_o, cpu_rdata_o, ram_addr_o, ram_we_o, ram_wdata_o
  );

  // Pixel path, CPU and RAM side
  modport master (
    output video_on_i, vga_addr_i, cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_rdata_i,
    input  vga_pixel_o, vga_stall_o, cpu_ack_o, cpu_rdata_o, ram_addr_o, ram_we_o, ram_wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
// +-------------------------------------------------------------------------+
// | vga_mem_arbiter : single-port image RAM shared by VGA fetch and CPU port |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module vga_mem_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  vga_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_WAIT = 2'd1,
    CPU_ACK  = 2'd2
  } cpu_state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  cpu_state_e        cpu_state_q, cpu_state_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              tag_valid_q, tag_valid_d;
  logic              pend_vga_q, pend_vga_d;
  logic              pend_we_q, pend_we_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] vga_pixel_q, vga_pixel_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vga_stall_q, vga_stall_d;
  logic              cpu_ack_q, cpu_ack_d;

  logic vga_need;
  logic cpu_elig;
  logic grant_cpu;
  logic grant_vga;

  // A starved CPU pre-empts VGA; otherwise VGA wins and the CPU takes idle slots.
  always_comb begin
    vga_need  = bus.video_on_i & (!tag_valid_q | (bus.vga_addr_i != tag_q));
    cpu_elig  = bus.cpu_req_i & (cpu_state_q == CPU_IDLE);
    grant_cpu = cpu_elig & ((starve_cnt_q >= LIMIT) | !vga_need);
    grant_vga = vga_need & !grant_cpu;
  end

  always_comb begin
    cpu_state_d  = cpu_state_q;
    tag_d        = tag_q;
    tag_valid_d  = tag_valid_q;
    ram_addr_d   = ram_addr_q;
    pend_we_d    = pend_we_q;
    starve_cnt_d = starve_cnt_q;
    vga_pixel_d  = vga_pixel_q;
    cpu_rdata_d  = cpu_rdata_q;
    pend_vga_d   = grant_vga;
    vga_stall_d  = vga_need & !grant_vga;
    cpu_ack_d    = (cpu_state_q == CPU_WAIT);

    case (cpu_state_q)
      CPU_IDLE: if (grant_cpu) cpu_state_d = CPU_WAIT;
      CPU_WAIT: cpu_state_d = CPU_ACK;
      CPU_ACK:  cpu_state_d = CPU_IDLE;
      default:  cpu_state_d = CPU_IDLE;
    endcase

    if ((cpu_state_q == CPU_WAIT) && !pend_we_q) cpu_rdata_d = bus.ram_rdata_i;
    if (pend_vga_q) vga_pixel_d = bus.ram_rdata_i;

    if (grant_cpu) begin
      ram_addr_d   = bus.cpu_addr_i;
      pend_we_d    = bus.cpu_we_i;
      starve_cnt_d = '0;
      // Writing the cached word forces a refetch; an in-flight VGA read keeps the old word.
      if (bus.cpu_we_i && tag_valid_q && (bus.cpu_addr_i == tag_q)) tag_valid_d = 1'b0;
    end else if (grant_vga) begin
      ram_addr_d  = bus.vga_addr_i;
      tag_d       = bus.vga_addr_i;
      tag_valid_d = 1'b1;
      if (cpu_elig && (starve_cnt_q != 8'hFF)) starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_state_q  <= CPU_IDLE;
      tag_q        <= '0;
      tag_valid_q  <= 1'b0;
      ram_addr_q   <= '0;
      pend_vga_q   <= 1'b0;
      pend_we_q    <= 1'b0;
      starve_cnt_q <= '0;
      vga_pixel_q  <= '0;
      cpu_rdata_q  <= '0;
      vga_stall_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
    end else begin
      cpu_state_q  <= cpu_state_d;
      tag_q        <= tag_d;
      tag_valid_q  <= tag_valid_d;
      ram_addr_q   <= ram_addr_d;
      pend_vga_q   <= pend_vga_d;
      pend_we_q    <= pend_we_d;
      starve_cnt_q <= starve_cnt_d;
      vga_pixel_q  <= vga_pixel_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vga_stall_q  <= vga_stall_d;
      cpu_ack_q    <= cpu_ack_d;
    end
  end

  // Idle cycles keep the last address on the RAM bus.
  assign bus.ram_addr_o  = ram_addr_d;
  assign bus.ram_we_o    = grant_cpu & bus.cpu_we_i;
  assign bus.ram_wdata_o = bus.cpu_wdata_i;
  assign bus.vga_pixel_o = vga_pixel_q;
  assign bus.vga_stall_o = vga_stall_q;
  assign bus.cpu_ack_o   = cpu_ack_q;
  assign bus.cpu_rdata_o = cpu_rdata_q;

endmodule

`default_nettype wire
